// File: rtl/sram_param_rw_pkg.sv
// Shared definitions for the parametrised SRAM: clear-FSM state encoding and byte geometry.
package sram_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } sram_state_e;

    function automatic int unsigned n_bytes(input int unsigned width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/sram_param_rw_if.sv
// User-side access bus of sram_param_rw: memory port, read strobe and bulk-clear handshake.
interface sram_param_rw_if #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned ADDR_W = 11
) ();

    logic                 CEN;
    logic                 WEN;
    logic [ADDR_W-1:0]    A;
    logic [WIDTH-1:0]     D;
    logic [WIDTH/8-1:0]   BM;
    logic [WIDTH-1:0]     Q;
    logic                 q_valid;
    logic                 clr_req;
    logic                 busy;
    logic                 clr_done;

    modport master (
        output CEN, WEN, A, D, BM, clr_req,
        input  Q, q_valid, busy, clr_done
    );

    modport slave (
        input  CEN, WEN, A, D, BM, clr_req,
        output Q, q_valid, busy, clr_done
    );

endinterface

// File: rtl/sram_param_core.sv
// Storage array: byte-masked synchronous write, registered read, no reset on contents.
module sram_param_core
    import sram_pkg::*;
#(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          we_i,
    input  logic                          re_i,
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [WIDTH-1:0]              wdata_i,
    input  logic [n_bytes(WIDTH)-1:0]     be_i,
    output logic [WIDTH-1:0]              rdata_o
);

    localparam int unsigned NB = n_bytes(WIDTH);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic             in_range;

    // Addresses beyond DEPTH only occur for non-power-of-two depths.
    assign in_range = ({1'b0, addr_i} < DEPTH_W);

    always_ff @(posedge clk_i) begin
        if (we_i && in_range) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
        if (re_i) begin
            rdata_q <= in_range ? mem[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_param_rw.sv
// Parametrised single-port SRAM with byte mask, read-valid strobe and a bulk-clear engine.
module sram_param_rw
    import sram_pkg::*;
#(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned OUT_REG = 0
) (
    input  logic            CLK,
    input  logic            reset,
    sram_param_rw_if.slave  bus
);

    localparam int unsigned     NB   = n_bytes(WIDTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    sram_state_e        state_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic               busy_q;
    logic               done_q;

    logic               core_we;
    logic               core_re;
    logic [ADDR_W-1:0]  core_addr;
    logic [WIDTH-1:0]   core_wdata;
    logic [NB-1:0]      core_be;
    logic [WIDTH-1:0]   core_rdata;

    // busy/clr_done are registered from the state, so they trail it by one cycle.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= (state_q == CLEAR);
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (bus.clr_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        core_we    = 1'b0;
        core_re    = 1'b0;
        core_addr  = bus.A;
        core_wdata = bus.D;
        core_be    = bus.BM;
        if (state_q == CLEAR) begin
            core_we    = 1'b1;
            core_addr  = cnt_q;
            core_wdata = '0;
            core_be    = '1;
        end else if (!bus.CEN) begin
            core_we = !bus.WEN;
            core_re = bus.WEN;
        end
    end

    sram_param_core #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk_i   (CLK),
        .we_i    (core_we),
        .re_i    (core_re),
        .addr_i  (core_addr),
        .wdata_i (core_wdata),
        .be_i    (core_be),
        .rdata_o (core_rdata)
    );

    logic               rd_q;
    logic               v1_q;
    logic [WIDTH-1:0]   q1_q;

    // Q stages load only on a completed read, so writes and clears never disturb Q.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rd_q <= 1'b0;
            v1_q <= 1'b0;
            q1_q <= '0;
        end else begin
            rd_q <= core_re;
            v1_q <= rd_q;
            if (rd_q) begin
                q1_q <= core_rdata;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic               v2_q;
        logic [WIDTH-1:0]   q2_q;

        always_ff @(posedge CLK or negedge reset) begin
            if (!reset) begin
                v2_q <= 1'b0;
                q2_q <= '0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    q2_q <= q1_q;
                end
            end
        end

        assign bus.Q       = q2_q;
        assign bus.q_valid = v2_q;
    end else begin : g_noreg
        assign bus.Q       = q1_q;
        assign bus.q_valid = v1_q;
    end

    assign bus.busy     = busy_q;
    assign bus.clr_done = done_q;

endmodule
